// File: rtl/details.sv
// Shared types for the accumulator-core control unit:
// opcodes, ALU ops, register enable bundles, bus sources.
package details;

    typedef enum logic [7:0] {
        NOP      = 8'h00,
        CLAC     = 8'h01,
        ADD      = 8'h02,
        SUB      = 8'h03,
        MUL      = 8'h04,
        INCAC    = 8'h05,
        MV_RL_AC = 8'h10,
        MV_RP_AC = 8'h11,
        MV_RQ_AC = 8'h12,
        MV_RC_AC = 8'h13,
        MV_R_AC  = 8'h14,
        MV_R1_AC = 8'h15,
        MV_AC_RP = 8'h20,
        MV_AC_RQ = 8'h21,
        MV_AC_RL = 8'h22,
        LDAC     = 8'h30,
        STR      = 8'h31,
        LDIAC    = 8'h32,
        STIR     = 8'h33,
        JUMP     = 8'h40,
        JMPZ     = 8'h41,
        JMPNZ    = 8'h42,
        ENDOP    = 8'hF0
    } ISA_t;

    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_CLR,
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_INC
    } alu_op_t;

    typedef struct packed {
        logic pc;
        logic rc;
        logic rp;
        logic rq;
    } inc_reg_t;

    typedef struct packed {
        logic ar;
        logic r;
        logic pc;
        logic ir;
        logic rl;
        logic rc;
        logic rp;
        logic rq;
        logic r1;
        logic ac;
    } wrEnReg_t;

    typedef enum logic [3:0] {
        BUS_PC,
        BUS_MEM,
        BUS_AC,
        BUS_R,
        BUS_RL,
        BUS_RP,
        BUS_RQ,
        BUS_RC,
        BUS_R1,
        BUS_AR
    } bus_in_sel_t;

endpackage

// File: rtl/control_unit.sv
// Fetch/execute sequencer for one accumulator core.
// Outputs come from the state register plus the registered IR and Z.
module control_unit
    import details::*;
#(
    parameter int IR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                start,
    input  logic                Zout,
    input  logic [IR_WIDTH-1:0] instruction,
    output alu_op_t             aluOp,
    output inc_reg_t            incReg,
    output wrEnReg_t            wrEnReg,
    output bus_in_sel_t         busSel,
    output logic                DataMemWrEn,
    output logic                ZWrEn,
    output logic                done,
    output logic                ready
);

    typedef enum logic [4:0] {
        S_IDLE,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_EXEC1,
        S_LD_WAIT,
        S_LD_LOAD,
        S_ST_WRITE,
        S_ST_SETTLE,
        S_LDI_WAIT,
        S_LDI_ADDR,
        S_STI_WAIT,
        S_STI_ADDR,
        S_JMP_WAIT,
        S_JMP_LOAD,
        S_END
    } state_t;

    state_t state, next;
    ISA_t   op;

    assign op = ISA_t'(instruction[7:0]);

    always_ff @(posedge clk) begin
        if (rstN) state <= S_IDLE;
        else      state <= next;
    end

    always_comb begin
        next        = state;
        aluOp       = ALU_PASS;
        incReg      = '0;
        wrEnReg     = '0;
        busSel      = BUS_PC;
        DataMemWrEn = 1'b0;
        ZWrEn       = 1'b0;
        done        = 1'b0;
        ready       = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) next = S_FETCH1;
            end
            S_FETCH1: begin
                wrEnReg.ar = 1'b1;
                next       = S_FETCH2;
            end
            S_FETCH2: next = S_FETCH3;
            S_FETCH3: begin
                busSel     = BUS_MEM;
                wrEnReg.ir = 1'b1;
                incReg.pc  = 1'b1;
                next       = S_EXEC1;
            end
            S_EXEC1: begin
                next = S_FETCH1;
                case (op)
                    CLAC: begin
                        aluOp = ALU_CLR; wrEnReg.ac = 1'b1; ZWrEn = 1'b1;
                    end
                    ADD: begin
                        aluOp = ALU_ADD; wrEnReg.ac = 1'b1; ZWrEn = 1'b1;
                    end
                    SUB: begin
                        aluOp = ALU_SUB; wrEnReg.ac = 1'b1; ZWrEn = 1'b1;
                    end
                    MUL: begin
                        aluOp = ALU_MUL; wrEnReg.ac = 1'b1; ZWrEn = 1'b1;
                    end
                    INCAC: begin
                        aluOp = ALU_INC; wrEnReg.ac = 1'b1; ZWrEn = 1'b1;
                    end
                    MV_RL_AC: begin busSel = BUS_AC; wrEnReg.rl = 1'b1; end
                    MV_RP_AC: begin busSel = BUS_AC; wrEnReg.rp = 1'b1; end
                    MV_RQ_AC: begin busSel = BUS_AC; wrEnReg.rq = 1'b1; end
                    MV_RC_AC: begin busSel = BUS_AC; wrEnReg.rc = 1'b1; end
                    MV_R_AC:  begin busSel = BUS_AC; wrEnReg.r  = 1'b1; end
                    MV_R1_AC: begin busSel = BUS_AC; wrEnReg.r1 = 1'b1; end
                    MV_AC_RP: begin busSel = BUS_RP; wrEnReg.ac = 1'b1; end
                    MV_AC_RQ: begin busSel = BUS_RQ; wrEnReg.ac = 1'b1; end
                    MV_AC_RL: begin busSel = BUS_RL; wrEnReg.ac = 1'b1; end
                    LDAC: begin
                        busSel = BUS_AC; wrEnReg.ar = 1'b1; next = S_LD_WAIT;
                    end
                    STR: begin
                        busSel = BUS_AC; wrEnReg.ar = 1'b1; next = S_ST_WRITE;
                    end
                    LDIAC: begin
                        wrEnReg.ar = 1'b1; next = S_LDI_WAIT;
                    end
                    STIR: begin
                        wrEnReg.ar = 1'b1; next = S_STI_WAIT;
                    end
                    JUMP: begin
                        wrEnReg.ar = 1'b1; next = S_JMP_WAIT;
                    end
                    // Untaken branches just skip the operand word
                    JMPZ: begin
                        if (Zout) begin
                            wrEnReg.ar = 1'b1; next = S_JMP_WAIT;
                        end else begin
                            incReg.pc = 1'b1;
                        end
                    end
                    JMPNZ: begin
                        if (!Zout) begin
                            wrEnReg.ar = 1'b1; next = S_JMP_WAIT;
                        end else begin
                            incReg.pc = 1'b1;
                        end
                    end
                    ENDOP:   next = S_END;
                    default: ;
                endcase
            end
            S_LD_WAIT: next = S_LD_LOAD;
            S_LD_LOAD: begin
                busSel = BUS_MEM; wrEnReg.ac = 1'b1; next = S_FETCH1;
            end
            S_ST_WRITE: begin
                busSel = BUS_R; DataMemWrEn = 1'b1; next = S_ST_SETTLE;
            end
            S_ST_SETTLE: next = S_FETCH1;
            S_LDI_WAIT:  next = S_LDI_ADDR;
            S_LDI_ADDR: begin
                busSel = BUS_MEM; wrEnReg.ar = 1'b1; incReg.pc = 1'b1;
                next = S_LD_WAIT;
            end
            S_STI_WAIT: next = S_STI_ADDR;
            S_STI_ADDR: begin
                busSel = BUS_MEM; wrEnReg.ar = 1'b1; incReg.pc = 1'b1;
                next = S_ST_WRITE;
            end
            S_JMP_WAIT: next = S_JMP_LOAD;
            S_JMP_LOAD: begin
                busSel = BUS_MEM; wrEnReg.pc = 1'b1; next = S_FETCH1;
            end
            S_END:   done = 1'b1;
            default: next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed vector bench for control_unit: per-opcode table
// plus cycle-exact traces for multi-cycle and reset cases.
module tb_control_unit;
    import details::*;

    logic        clk = 1'b0;
    logic        rstN, start, Zout;
    logic [7:0]  instruction;
    alu_op_t     aluOp;
    inc_reg_t    incReg;
    wrEnReg_t    wrEnReg;
    bus_in_sel_t busSel;
    logic        DataMemWrEn, ZWrEn, done, ready;
    logic [24:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    control_unit #(.IR_WIDTH(8)) dut (
        .clk(clk), .rstN(rstN), .start(start), .Zout(Zout),
        .instruction(instruction), .aluOp(aluOp), .incReg(incReg),
        .wrEnReg(wrEnReg), .busSel(busSel), .DataMemWrEn(DataMemWrEn),
        .ZWrEn(ZWrEn), .done(done), .ready(ready)
    );

    always #5 clk = ~clk;

    assign obs = {aluOp, incReg, wrEnReg, busSel,
                  DataMemWrEn, ZWrEn, done, ready};

    localparam logic [9:0] W_0  = 10'b0000000000;
    localparam logic [9:0] W_AR = 10'b1000000000;
    localparam logic [9:0] W_R  = 10'b0100000000;
    localparam logic [9:0] W_PC = 10'b0010000000;
    localparam logic [9:0] W_IR = 10'b0001000000;
    localparam logic [9:0] W_RL = 10'b0000100000;
    localparam logic [9:0] W_RC = 10'b0000010000;
    localparam logic [9:0] W_RP = 10'b0000001000;
    localparam logic [9:0] W_RQ = 10'b0000000100;
    localparam logic [9:0] W_R1 = 10'b0000000010;
    localparam logic [9:0] W_AC = 10'b0000000001;
    localparam logic [3:0] I_0  = 4'b0000;
    localparam logic [3:0] I_PC = 4'b1000;

    function automatic logic [24:0] mk(alu_op_t a, logic [3:0] i,
        logic [9:0] w, bus_in_sel_t b, logic d, logic z,
        logic dn, logic rd);
        return {a, i, w, b, d, z, dn, rd};
    endfunction

    typedef struct {
        logic [7:0]  op;
        logic        z;
        logic [24:0] exp;
        int          ncyc;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [24:0] tr[1:12];
    logic [24:0] IDLE_O, F1, F3, BUSY, AR_PC, IND_ADDR;
    int          dmw_seen;

    function automatic vec_t v(logic [7:0] op, logic z, alu_op_t a,
        logic [3:0] i, logic [9:0] w, bus_in_sel_t b, logic zw,
        int n, string nm);
        vec_t r;
        r.op = op; r.z = z; r.ncyc = n; r.name = nm;
        r.exp = mk(a, i, w, b, 1'b0, zw, 1'b0, 1'b0);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [24:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic chk_int(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Entered with cycle 1 (FETCH1) already sampled; leaves at next FETCH1
    task automatic run_vec(vec_t t);
        instruction = t.op;
        Zout = t.z;
        chk({t.name, " fetch1"}, F1);
        step();
        step();
        chk({t.name, " fetch3"}, F3);
        step();
        chk({t.name, " exec"}, t.exp);
        for (int c = 5; c <= t.ncyc + 1; c++) step();
        chk({t.name, " next fetch1"}, F1);
    endtask

    task automatic check_trace(string name, int n);
        dmw_seen = 0;
        for (int c = 1; c <= n; c++) begin
            chk($sformatf("%s c%0d", name, c), tr[c]);
            if (DataMemWrEn) dmw_seen++;
            if (c < n) step();
        end
    endtask

    initial begin
        IDLE_O   = mk(ALU_PASS, I_0, W_0, BUS_PC, 0, 0, 0, 1);
        BUSY     = mk(ALU_PASS, I_0, W_0, BUS_PC, 0, 0, 0, 0);
        F1       = mk(ALU_PASS, I_0, W_AR, BUS_PC, 0, 0, 0, 0);
        F3       = mk(ALU_PASS, I_PC, W_IR, BUS_MEM, 0, 0, 0, 0);
        AR_PC    = F1;
        IND_ADDR = mk(ALU_PASS, I_PC, W_AR, BUS_MEM, 0, 0, 0, 0);

        vecs.push_back(v(NOP, 0, ALU_PASS, I_0, W_0, BUS_PC, 0, 4, "NOP"));
        vecs.push_back(v(8'hEE, 0, ALU_PASS, I_0, W_0, BUS_PC, 0, 4, "UNDEF"));
        vecs.push_back(v(CLAC, 0, ALU_CLR, I_0, W_AC, BUS_PC, 1, 4, "CLAC"));
        vecs.push_back(v(ADD, 1, ALU_ADD, I_0, W_AC, BUS_PC, 1, 4, "ADD"));
        vecs.push_back(v(SUB, 0, ALU_SUB, I_0, W_AC, BUS_PC, 1, 4, "SUB"));
        vecs.push_back(v(MUL, 0, ALU_MUL, I_0, W_AC, BUS_PC, 1, 4, "MUL"));
        vecs.push_back(v(INCAC, 1, ALU_INC, I_0, W_AC, BUS_PC, 1, 4, "INCAC"));
        vecs.push_back(v(MV_RL_AC, 0, ALU_PASS, I_0, W_RL, BUS_AC, 0, 4, "MV_RL_AC"));
        vecs.push_back(v(MV_RP_AC, 0, ALU_PASS, I_0, W_RP, BUS_AC, 0, 4, "MV_RP_AC"));
        vecs.push_back(v(MV_RQ_AC, 0, ALU_PASS, I_0, W_RQ, BUS_AC, 0, 4, "MV_RQ_AC"));
        vecs.push_back(v(MV_RC_AC, 0, ALU_PASS, I_0, W_RC, BUS_AC, 0, 4, "MV_RC_AC"));
        vecs.push_back(v(MV_R_AC, 0, ALU_PASS, I_0, W_R, BUS_AC, 0, 4, "MV_R_AC"));
        vecs.push_back(v(MV_R1_AC, 0, ALU_PASS, I_0, W_R1, BUS_AC, 0, 4, "MV_R1_AC"));
        vecs.push_back(v(MV_AC_RP, 0, ALU_PASS, I_0, W_AC, BUS_RP, 0, 4, "MV_AC_RP"));
        vecs.push_back(v(MV_AC_RQ, 0, ALU_PASS, I_0, W_AC, BUS_RQ, 0, 4, "MV_AC_RQ"));
        vecs.push_back(v(MV_AC_RL, 0, ALU_PASS, I_0, W_AC, BUS_RL, 0, 4, "MV_AC_RL"));
        vecs.push_back(v(LDAC, 0, ALU_PASS, I_0, W_AR, BUS_AC, 0, 6, "LDAC"));
        vecs.push_back(v(STR, 0, ALU_PASS, I_0, W_AR, BUS_AC, 0, 6, "STR"));
        vecs.push_back(v(LDIAC, 0, ALU_PASS, I_0, W_AR, BUS_PC, 0, 8, "LDIAC"));
        vecs.push_back(v(STIR, 0, ALU_PASS, I_0, W_AR, BUS_PC, 0, 8, "STIR"));
        vecs.push_back(v(JUMP, 0, ALU_PASS, I_0, W_AR, BUS_PC, 0, 6, "JUMP"));
        vecs.push_back(v(JMPZ, 1, ALU_PASS, I_0, W_AR, BUS_PC, 0, 6, "JMPZ_T"));
        vecs.push_back(v(JMPZ, 0, ALU_PASS, I_PC, W_0, BUS_PC, 0, 4, "JMPZ_NT"));
        vecs.push_back(v(JMPNZ, 0, ALU_PASS, I_0, W_AR, BUS_PC, 0, 6, "JMPNZ_T"));
        vecs.push_back(v(JMPNZ, 1, ALU_PASS, I_PC, W_0, BUS_PC, 0, 4, "JMPNZ_NT"));

        rstN = 1'b1; start = 1'b0; Zout = 1'b0; instruction = NOP;
        step();
        chk("reset idle", IDLE_O);
        rstN = 1'b0;
        step();
        chk("idle hold", IDLE_O);
        start = 1'b1;
        step();

        // start stays high: it must be ignored once out of IDLE
        foreach (vecs[i]) run_vec(vecs[i]);

        instruction = STIR;
        tr[1] = F1; tr[2] = BUSY; tr[3] = F3; tr[4] = AR_PC;
        tr[5] = BUSY; tr[6] = IND_ADDR;
        tr[7] = mk(ALU_PASS, I_0, W_0, BUS_R, 1, 0, 0, 0);
        tr[8] = BUSY; tr[9] = F1;
        check_trace("STIR", 9);
        chk_int("STIR dmw count", dmw_seen, 1);

        instruction = LDIAC;
        tr[7] = BUSY;
        tr[8] = mk(ALU_PASS, I_0, W_AC, BUS_MEM, 0, 0, 0, 0);
        check_trace("LDIAC", 9);
        chk_int("LDIAC dmw count", dmw_seen, 0);

        instruction = JMPZ; Zout = 1'b1;
        tr[6] = mk(ALU_PASS, I_0, W_PC, BUS_MEM, 0, 0, 0, 0);
        tr[7] = F1;
        check_trace("JMPZ taken", 7);

        instruction = STR; Zout = 1'b0;
        tr[4] = mk(ALU_PASS, I_0, W_AR, BUS_AC, 0, 0, 0, 0);
        tr[5] = mk(ALU_PASS, I_0, W_0, BUS_R, 1, 0, 0, 0);
        tr[6] = BUSY; tr[7] = F1;
        check_trace("STR", 7);
        chk_int("STR dmw count", dmw_seen, 1);

        // reset in the middle of an indirect load
        instruction = LDIAC;
        for (int c = 1; c < 5; c++) step();
        rstN = 1'b1;
        step();
        chk("mid reset idle", IDLE_O);
        rstN = 1'b0; start = 1'b0;
        step();
        chk("mid reset hold", IDLE_O);
        start = 1'b1;
        step();

        instruction = ENDOP;
        chk("ENDOP fetch1", F1);
        step(); step(); step();
        chk("ENDOP exec", BUSY);
        for (int c = 5; c <= 8; c++) begin
            step();
            instruction = ADD;
            chk($sformatf("END c%0d", c),
                mk(ALU_PASS, I_0, W_0, BUS_PC, 0, 0, 1, 0));
        end
        rstN = 1'b1;
        step();
        chk("END reset", IDLE_O);
        rstN = 1'b0; start = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
